// File: rtl/alu_pkg.sv
// Shared types and sizes for the ALU issue controller and its register file.
package alu_pkg;

  localparam int unsigned NUM_REGS = 4;
  localparam int unsigned DATA_W   = 4;
  localparam int unsigned IDX_W    = 2;
  localparam int unsigned SEL_W    = 4;
  localparam int unsigned OPCNT_W  = 8;

  typedef logic [DATA_W-1:0]  nibble_t;
  typedef logic [IDX_W-1:0]   reg_idx_t;
  typedef logic [SEL_W-1:0]   alu_sel_t;
  typedef logic [OPCNT_W-1:0] opcnt_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } issue_state_t;

  // Control fields latched at accept and presented to the ALU during ISSUE.
  typedef struct packed {
    alu_sel_t sel;
    logic     m;
    logic     cn;
    reg_idx_t rd;
  } alu_ctl_t;

  function automatic logic is_all_ones(input nibble_t v);
    return v == '1;
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// 4 x 4-bit register file: two asynchronous read ports, one synchronous write port.
module alu_regfile
  import alu_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  reg_idx_t ra_addr,
  input  reg_idx_t rb_addr,
  output nibble_t  ra_data,
  output nibble_t  rb_data,
  input  logic     we,
  input  reg_idx_t wa,
  input  nibble_t  wd
);

  nibble_t rf_q [NUM_REGS];
  nibble_t rf_d [NUM_REGS];

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) rf_d[i] = rf_q[i];
    if (we) rf_d[wa] = wd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= rf_d[i];
    end
  end

  assign ra_data = rf_q[ra_addr];
  assign rb_data = rf_q[rb_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues register-file operands to an external ALU and writes its result back.
// Optional completed-op counter enabled by defining ALU_ISSUE_OPCNT_EN.
module alu_issue_ctrl
  import alu_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [SEL_W-1:0]    instr_sel,
  input  logic                instr_m,
  input  logic                instr_cn,
  input  logic [IDX_W-1:0]    instr_ra,
  input  logic [IDX_W-1:0]    instr_rb,
  input  logic [IDX_W-1:0]    instr_rd,
  input  logic                instr_imm_en,
  input  logic [DATA_W-1:0]   instr_imm,
  output logic [SEL_W-1:0]    alu_sel,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  output logic                alu_m,
  output logic                alu_cn,
  input  logic [DATA_W-1:0]   alu_f,
  input  logic                alu_abflag,
  output logic                res_valid,
  output logic [DATA_W-1:0]   res_data,
  output logic [IDX_W-1:0]    res_rd,
  output logic                res_allone,
  output logic [OPCNT_W-1:0]  op_cnt
);

  issue_state_t state_q, state_d;
  logic         ready_q, ready_d;
  alu_ctl_t     ctl_q, ctl_d;
  nibble_t      a_q, a_d, b_q, b_d;
  logic         res_valid_q, res_valid_d;
  nibble_t      res_data_q, res_data_d;
  reg_idx_t     res_rd_q, res_rd_d;
  logic         res_allone_q, res_allone_d;

  logic     accept;
  logic     rf_we;
  reg_idx_t rf_wa;
  nibble_t  rf_wd;
  nibble_t  rf_ra_data, rf_rb_data;

  assign accept = instr_valid && ready_q;

  alu_regfile u_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .ra_addr (instr_ra),
    .rb_addr (instr_rb),
    .ra_data (rf_ra_data),
    .rb_data (rf_rb_data),
    .we      (rf_we),
    .wa      (rf_wa),
    .wd      (rf_wd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ready_q      <= 1'b1;
      ctl_q        <= '{sel: '0, m: 1'b0, cn: 1'b1, rd: '0};
      a_q          <= '0;
      b_q          <= '0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_rd_q     <= '0;
      res_allone_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      ctl_q        <= ctl_d;
      a_q          <= a_d;
      b_q          <= b_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      res_rd_q     <= res_rd_d;
      res_allone_q <= res_allone_d;
    end
  end

  // Immediates complete in IDLE; only ALU instructions visit ISSUE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && !instr_imm_en) state_d = ISSUE;
      ISSUE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready_d      = 1'b1;
    ctl_d        = ctl_q;
    a_d          = a_q;
    b_d          = b_q;
    res_valid_d  = 1'b0;
    res_data_d   = res_data_q;
    res_rd_d     = res_rd_q;
    res_allone_d = res_allone_q;
    rf_we        = 1'b0;
    rf_wa        = '0;
    rf_wd        = '0;
    case (state_q)
      IDLE: begin
        if (accept && instr_imm_en) begin
          rf_we        = 1'b1;
          rf_wa        = instr_rd;
          rf_wd        = instr_imm;
          res_valid_d  = 1'b1;
          res_data_d   = instr_imm;
          res_rd_d     = instr_rd;
          res_allone_d = is_all_ones(instr_imm);
        end else if (accept) begin
          ctl_d = '{sel: instr_sel, m: instr_m, cn: instr_cn, rd: instr_rd};
          a_d   = rf_ra_data;
          b_d   = rf_rb_data;
        end
      end
      ISSUE: begin
        rf_we        = 1'b1;
        rf_wa        = ctl_q.rd;
        rf_wd        = alu_f;
        res_valid_d  = 1'b1;
        res_data_d   = alu_f;
        res_rd_d     = ctl_q.rd;
        res_allone_d = alu_abflag;
      end
      default: ;
    endcase
    ready_d = (state_d == IDLE);
  end

`ifdef ALU_ISSUE_OPCNT_EN
  opcnt_t opcnt_q, opcnt_d;

  // Saturating count of completed ALU operations.
  always_comb begin
    opcnt_d = opcnt_q;
    if (state_q == ISSUE && opcnt_q != '1) opcnt_d = opcnt_q + OPCNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) opcnt_q <= '0;
    else        opcnt_q <= opcnt_d;
  end

  assign op_cnt = opcnt_q;
`else
  assign op_cnt = '0;
`endif

  assign instr_ready = ready_q;
  assign alu_sel     = ctl_q.sel;
  assign alu_m       = ctl_q.m;
  assign alu_cn      = ctl_q.cn;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_rd      = res_rd_q;
  assign res_allone  = res_allone_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a small behavioural ALU model.
module tb_alu_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       instr_valid, instr_ready;
  logic [3:0] instr_sel;
  logic       instr_m, instr_cn;
  logic [1:0] instr_ra, instr_rb, instr_rd;
  logic       instr_imm_en;
  logic [3:0] instr_imm;
  logic [3:0] alu_sel, alu_a, alu_b;
  logic       alu_m, alu_cn;
  logic [3:0] alu_f;
  logic       alu_abflag;
  logic       res_valid;
  logic [3:0] res_data;
  logic [1:0] res_rd;
  logic       res_allone;
  logic [7:0] op_cnt;

  logic force_f = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   alu_ops = 0;

  always #5 clk = ~clk;

  // ALU model: sel 14 adds, anything else XORs; force_f pins the result to all ones.
  assign alu_f      = force_f ? 4'hF : ((alu_sel == 4'd14) ? 4'(alu_a + alu_b) : (alu_a ^ alu_b));
  assign alu_abflag = force_f ? 1'b1 : (alu_f == 4'hF);

  alu_issue_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_sel    (instr_sel),
    .instr_m      (instr_m),
    .instr_cn     (instr_cn),
    .instr_ra     (instr_ra),
    .instr_rb     (instr_rb),
    .instr_rd     (instr_rd),
    .instr_imm_en (instr_imm_en),
    .instr_imm    (instr_imm),
    .alu_sel      (alu_sel),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_m        (alu_m),
    .alu_cn       (alu_cn),
    .alu_f        (alu_f),
    .alu_abflag   (alu_abflag),
    .res_valid    (res_valid),
    .res_data     (res_data),
    .res_rd       (res_rd),
    .res_allone   (res_allone),
    .op_cnt       (op_cnt)
  );

  typedef struct {
    bit       imm_en;
    bit [3:0] sel;
    bit       m;
    bit       cn;
    bit [1:0] ra, rb, rd;
    bit [3:0] imm;
    bit [3:0] exp_a, exp_b, exp_data;
    bit       exp_allone;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic int exp_opcnt(input int n);
`ifdef ALU_ISSUE_OPCNT_EN
    return (n > 255) ? 255 : n;
`else
    return 0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input vec_t v);
    instr_imm_en = v.imm_en;
    instr_sel    = v.sel;
    instr_m      = v.m;
    instr_cn     = v.cn;
    instr_ra     = v.ra;
    instr_rb     = v.rb;
    instr_rd     = v.rd;
    instr_imm    = v.imm;
  endtask

  // Offer one instruction, then check issue and writeback cycles.
  task automatic run_vec(input string tag, input vec_t v);
    int wait_cyc = 0;
    while (!instr_ready && wait_cyc < 10) begin
      tick();
      wait_cyc++;
    end
    if (!instr_ready) begin
      check({tag, " ready_timeout"}, 0, 1);
      return;
    end
    set_instr(v);
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    if (!v.imm_en) begin
      check({tag, " issue_ready"}, instr_ready, 0);
      check({tag, " alu_a"}, alu_a, v.exp_a);
      check({tag, " alu_b"}, alu_b, v.exp_b);
      check({tag, " alu_sel"}, alu_sel, v.sel);
      check({tag, " alu_m"}, alu_m, v.m);
      check({tag, " alu_cn"}, alu_cn, v.cn);
      check({tag, " early_valid"}, res_valid, 0);
      tick();
      alu_ops++;
    end
    check({tag, " res_valid"}, res_valid, 1);
    check({tag, " res_data"}, res_data, v.exp_data);
    check({tag, " res_rd"}, res_rd, v.rd);
    check({tag, " res_allone"}, res_allone, v.exp_allone);
    check({tag, " ready_after"}, instr_ready, 1);
  endtask

  initial begin
    int   acc;
    int   pulses;
    vec_t v;

    //          imm sel  m  cn ra rb rd imm    a     b     data  ao
    vecs[0] = '{1, 4'd0,  0, 1, 0, 0, 1, 4'h5, 4'h0, 4'h0, 4'h5, 0};
    vecs[1] = '{1, 4'd0,  0, 1, 0, 0, 2, 4'h3, 4'h0, 4'h0, 4'h3, 0};
    vecs[2] = '{0, 4'd14, 1, 0, 1, 2, 3, 4'h0, 4'h5, 4'h3, 4'h8, 0};
    vecs[3] = '{0, 4'd14, 0, 1, 3, 1, 3, 4'h0, 4'h8, 4'h5, 4'hD, 0};
    vecs[4] = '{0, 4'd0,  1, 1, 3, 3, 2, 4'h0, 4'hD, 4'hD, 4'h0, 0};
    vecs[5] = '{1, 4'd0,  0, 1, 0, 0, 0, 4'hF, 4'h0, 4'h0, 4'hF, 1};
    vecs[6] = '{0, 4'd14, 1, 1, 0, 1, 1, 4'h0, 4'hF, 4'h5, 4'h4, 0};
    vecs[7] = '{0, 4'd0,  1, 1, 0, 2, 1, 4'h0, 4'hF, 4'h0, 4'hF, 1};
    vecs[8] = '{1, 4'd0,  0, 1, 0, 0, 3, 4'hA, 4'h0, 4'h0, 4'hA, 0};

    instr_valid = 1'b0;
    set_instr(vecs[0]);
    rst_n = 1'b0;
    #12;
    rst_n = 1'b1;
    tick();

    check("rst ready", instr_ready, 1);
    check("rst res_valid", res_valid, 0);
    check("rst res_data", res_data, 0);
    check("rst alu_a", alu_a, 0);
    check("rst alu_cn", alu_cn, 1);
    check("rst alu_m", alu_m, 0);
    check("rst op_cnt", op_cnt, 0);

    for (int i = 0; i < 9; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i]);
      if (i == 2) begin
        check("rf3 after add", dut.u_rf.rf_q[3], 8);
        check("op_cnt first", op_cnt, exp_opcnt(alu_ops));
      end
    end
    tick();
    check("pulse end", res_valid, 0);
    check("rf0 final", dut.u_rf.rf_q[0], 4'hF);
    check("rf1 final", dut.u_rf.rf_q[1], 4'hF);
    check("rf2 final", dut.u_rf.rf_q[2], 4'h0);
    check("rf3 final", dut.u_rf.rf_q[3], 4'hA);

    // Continuous valid: rf1 += rf1 four times (F -> E -> C -> 8 -> 0).
    v = '{0, 4'd14, 1, 1, 1, 1, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0};
    set_instr(v);
    instr_valid = 1'b1;
    acc = 0;
    pulses = 0;
    for (int k = 1; k <= 10; k++) begin
      if (instr_valid && instr_ready) acc++;
      tick();
      if (acc == 4) instr_valid = 1'b0;
      if (res_valid) pulses++;
      check($sformatf("tput ready k%0d", k), instr_ready, ((k % 2 == 0) || k > 8) ? 1 : 0);
      check($sformatf("tput valid k%0d", k), res_valid, ((k % 2 == 0) && k <= 8) ? 1 : 0);
    end
    alu_ops += 4;
    check("tput accepts", acc, 4);
    check("tput pulses", pulses, 4);
    check("tput rf1", dut.u_rf.rf_q[1], 0);

    force_f = 1'b1;
    run_vec("force", '{0, 4'd14, 1, 1, 0, 3, 2, 4'h0, 4'hF, 4'hA, 4'hF, 1});
    force_f = 1'b0;
    check("op_cnt mid", op_cnt, exp_opcnt(alu_ops));

    // Reset pulse while an ALU op sits in ISSUE.
    set_instr('{0, 4'd14, 1, 1, 0, 0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0});
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    check("abort in_issue", instr_ready, 0);
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    check("abort res_valid", res_valid, 0);
    check("abort ready", instr_ready, 1);
    check("abort alu_cn", alu_cn, 1);
    check("abort alu_a", alu_a, 0);
    check("abort op_cnt", op_cnt, 0);
    for (int r = 0; r < 4; r++) check($sformatf("abort rf%0d", r), dut.u_rf.rf_q[r], 0);

    // 260 back-to-back ALU ops to exercise counter saturation.
    set_instr('{0, 4'd0, 0, 1, 0, 1, 2, 4'h0, 4'h0, 4'h0, 4'h0, 0});
    instr_valid = 1'b1;
    acc = 0;
    pulses = 0;
    for (int k = 0; k < 600 && pulses < 260; k++) begin
      if (instr_valid && instr_ready) acc++;
      tick();
      if (acc == 260) instr_valid = 1'b0;
      if (res_valid) pulses++;
    end
    instr_valid = 1'b0;
    check("sat pulses", pulses, 260);
    check("sat op_cnt", op_cnt, exp_opcnt(260));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low: clk input 1 (rising edge), rst_n input 1 (async assert, active-low).
REQ-002 The block SHALL have these ports: instr_valid in 1, instruction offered.
REQ-003 The block SHALL have: instr_ready out 1, block can accept.
REQ-004 The block SHALL have: instr_sel in 4, ALU function select.
REQ-005 The block SHALL have: instr_m in 1 (ALU mode) and instr_cn in 1 (ALU carry-in, active-low).
REQ-006 The block SHALL have: instr_ra, instr_rb, instr_rd in 2 each, source A, source B and destination register indices.
REQ-007 The block SHALL have: instr_imm_en in 1 (immediate load) and instr_imm in 4 (immediate value).
REQ-008 The block SHALL have: alu_sel out 4, alu_a out 4, alu_b out 4, alu_m out 1, alu_cn out 1, driving the downstream ALU.
REQ-009 The block SHALL have: alu_f in 4 (ALU result) and alu_abflag in 1 (ALU all-ones flag).
REQ-010 The block SHALL have: res_valid out 1, res_data out 4, res_rd out 2, res_allone out 1, reporting writeback.
REQ-011 The block SHALL have: op_cnt out 8, completed ALU operation count.

Function
REQ-012 The block SHALL contain a 4-entry x 4-bit register file (rf).
REQ-013 FSM states: IDLE, ISSUE.
REQ-014 instr_ready SHALL be 1 in IDLE and 0 in ISSUE.
REQ-015 Handshake: an instruction is accepted on a rising edge with instr_valid=1 and instr_ready=1; instr_valid is ignored while instr_ready=0.
REQ-016 ALU instruction (instr_imm_en=0) accepted in IDLE: at that edge latch sel, m, cn and rd, plus rf[ra] into alu_a and rf[rb] into alu_b; go to ISSUE.
REQ-017 ALU outputs alu_* SHALL be registered and stable for the whole ISSUE cycle.
REQ-018 At the ISSUE edge: sample alu_f into res_data and rf[rd], alu_abflag into res_allone, latched rd into res_rd; set res_valid=1; return to IDLE.
REQ-019 Immediate instruction accepted in IDLE: write instr_imm into rf[rd] and res_data; res_allone=(imm==4'hF); res_valid=1 next cycle; stay in IDLE; alu_* unchanged.
REQ-020 res_valid SHALL be a one-cycle pulse per completed instruction.
REQ-021 An ALU instruction has a latency of 2 cycles from accept edge to res_valid; throughput is one per 2 cycles.
REQ-022 An immediate instruction has a latency of 1 cycle; throughput is 1 per cycle.
REQ-023 Back-to-back RAW dependency: an instruction accepted in the cycle res_valid is high SHALL read the already-written value; no forwarding is needed because the write occurs at the prior edge.
REQ-024 With ra==rb, both operands SHALL read the same register.
REQ-025 When rd equals a source index, the block SHALL read the old value and write the new value.
REQ-026 All arithmetic is 4-bit; the block performs no computation on alu_f.

Reset
REQ-027 On rst_n=0, asynchronously:
- state=IDLE;
- rf all 0;
- alu_sel, alu_a, alu_b = 0;
- alu_m = 0;
- alu_cn = 1;
- res_valid, res_data, res_rd, res_allone = 0;
- op_cnt = 0.
REQ-028 Reset asserted during ISSUE SHALL abort the operation with no rf write and no res_valid.
REQ-029 instr_ready SHALL be 1 in the first cycle after reset release.

Configuration
REQ-030 Macro ALU_ISSUE_OPCNT_EN defined: op_cnt increments by 1 at each ISSUE completion and saturates at 8'hFF; immediates do not count.
REQ-031 Macro ALU_ISSUE_OPCNT_EN undefined: op_cnt is constant 0 and no counter logic exists.

Structure
REQ-032 Package alu_pkg SHALL hold:
- nibble_t (4-bit);
- reg_idx_t (2-bit);
- state enum issue_state_t {IDLE, ISSUE};
- NUM_REGS=4;
- OPCNT_W=8.
REQ-033 Sub-module alu_regfile (2 async read ports, 1 sync write port, async active-low reset) SHALL hold rf.

Verification
REQ-034 Reset then imm rd=1 imm=4'h5 -> next cycle res_valid=1, res_data=5, res_rd=1, res_allone=0, instr_ready stays 1.
REQ-035 rf1=5, rf2=3; ALU sel=14 m=1 ra=1 rb=2 rd=3, with ALU model -> ISSUE cycle alu_a=5, alu_b=3, instr_ready=0; next cycle res_data=8, rf3=8, op_cnt=1.
REQ-036 Dependent op accepted in the res_valid cycle, reading rd=3 -> alu_a=8.
REQ-037 instr_valid held high continuously for 4 ALU ops -> accepts exactly every 2nd cycle and 4 res_valid pulses.
REQ-038 Model forces alu_f=4'hF, alu_abflag=1 -> res_allone=1; rst_n pulsed low mid-ISSUE -> no res_valid and rf all 0.
REQ-039 With ALU_ISSUE_OPCNT_EN defined, 260 ALU ops -> op_cnt=255; without the macro, op_cnt=0 throughout.
